// File: rtl/iiitb_change_dispenser_if.sv
// iiitb_change_dispenser_if: request, coin-sense and hopper-drive bundle for the change dispenser
interface iiitb_change_dispenser_if;
    logic       req;
    logic [2:0] change;
    logic       coin_sense;
    logic       nickel_drv;
    logic       dime_drv;
    logic       busy;
    logic       done;
    logic       jam;
    logic [1:0] coins_left;
    modport master (output req, change, coin_sense,
                    input  nickel_drv, dime_drv, busy, done, jam, coins_left);
    modport slave  (input  req, change, coin_sense,
                    output nickel_drv, dime_drv, busy, done, jam, coins_left);
endinterface

// File: rtl/iiitb_change_dispenser.sv
// iiitb_change_dispenser: pulses nickel/dime hoppers one coin at a time, waits for the drop sensor, flags jams
module iiitb_change_dispenser #(
    parameter int PULSE_CYCLES = 4,
    parameter int TIMEOUT      = 200
) (
    input logic clock,
    input logic reset,
    iiitb_change_dispenser_if.slave bus
);
    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, DONE, JAM} state_t;
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);
    state_t     state, next;
    logic [1:0] nick, dime, nick_n, dime_n, left_d;
    logic [7:0] pcnt, tcnt, pcnt_n, tcnt_n;
    logic       nickel_d, dime_d, busy_d, done_d, jam_d;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            nick           <= '0;
            dime           <= '0;
            pcnt           <= '0;
            tcnt           <= '0;
            bus.nickel_drv <= 1'b0;
            bus.dime_drv   <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.jam        <= 1'b0;
            bus.coins_left <= '0;
        end else begin
            state          <= next;
            nick           <= nick_n;
            dime           <= dime_n;
            pcnt           <= pcnt_n;
            tcnt           <= tcnt_n;
            bus.nickel_drv <= nickel_d;
            bus.dime_drv   <= dime_d;
            bus.busy       <= busy_d;
            bus.done       <= done_d;
            bus.jam        <= jam_d;
            bus.coins_left <= left_d;
        end
    end
    always_comb begin
        next   = state;
        nick_n = nick;
        dime_n = dime;
        pcnt_n = pcnt;
        tcnt_n = tcnt;
        case (state)
            IDLE: if (bus.req) begin
                nick_n = {1'b0, bus.change == 3'b001 || bus.change == 3'b011};
                dime_n = bus.change == 3'b100 ? 2'd2 :
                         (bus.change == 3'b010 || bus.change == 3'b011) ? 2'd1 : 2'd0;
                pcnt_n = '0;
                next   = bus.change inside {3'b001, 3'b010, 3'b011, 3'b100} ? DRIVE : DONE;
            end
            DRIVE: if (pcnt == PULSE_LAST) begin
                next   = WAIT;
                tcnt_n = '0;
            end else pcnt_n = pcnt + 8'd1;
            // a drop on the timeout edge still counts as a coin
            WAIT: if (bus.coin_sense) begin
                nick_n = nick != 2'd0 ? nick - 2'd1 : nick;
                dime_n = nick != 2'd0 ? dime : dime - 2'd1;
                pcnt_n = '0;
                next   = (nick_n + dime_n) != 2'd0 ? DRIVE : DONE;
            end else if (tcnt == WAIT_LAST) next = JAM;
            else tcnt_n = tcnt + 8'd1;
            DONE:    next = IDLE;
            default: next = JAM;
        endcase
    end
    always_comb begin
        nickel_d = next == DRIVE && nick_n != 2'd0;
        dime_d   = next == DRIVE && nick_n == 2'd0;
        busy_d   = next == DRIVE || next == WAIT || next == JAM;
        done_d   = next == DONE;
        jam_d    = next == JAM;
        left_d   = nick_n + dime_n;
    end
endmodule
